proc_phase_sequencer: RTL and testbench
=======================================

// Module: proc_phase_sequencer
// PURPOSE
//   Multicycle instruction phase sequencer clocked by the system clock generator.
//   Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
//   Emits one-hot phase enables to the datapath and drives a req/ack memory handshake.
//   Counts retired instructions and flags HALT and memory-timeout conditions.
// PARAMETERS
//   MEM_TIMEOUT  15  no-ack cycles tolerated in FETCH/MEM before ERR; 0 = timeout disabled
//   CNT_W        32  width of retired-instruction counter
// PORTS
//   CLK           in   1      system clock (CLK_GENERATOR output); single clock domain
//   RST           in   1      reset; synchronous, active-high
//   RUN           in   1      start/continue execution
//   HALT_REQ      in   1      decoder flags halt instruction; sampled only in DECODE
//   NEED_MEM      in   1      current instruction needs MEM phase; sampled only in EXEC
//   MEM_ACK       in   1      memory completes request; sampled only in FETCH/MEM
//   MEM_REQ       out  1      memory request, high throughout FETCH and MEM
//   PH_FETCH      out  1      phase enable: fetch
//   PH_DECODE     out  1      phase enable: decode
//   PH_EXEC       out  1      phase enable: execute
//   PH_MEM        out  1      phase enable: memory
//   PH_WB         out  1      phase enable: write-back
//   RETIRE        out  1      one-cycle pulse, equals PH_WB
//   HALTED        out  1      sticky; set in HALT state
//   MEM_ERR       out  1      sticky; set in ERR state
//   INSTR_CNT     out  CNT_W  retired-instruction count
// BEHAVIOUR
//   - Moore FSM; all outputs decoded from the state register. PH_* one-hot or all-zero.
//   - Reset: state IDLE; all outputs 0; INSTR_CNT 0; wait counter 0. RST overrides everything.
//   - IDLE:   RUN=1 -> FETCH, else stay.
//   - FETCH:  MEM_REQ=1, PH_FETCH=1. MEM_ACK=1 -> DECODE.
//             MEM_ACK=0 and timeout hit -> ERR. Otherwise stay.
//   - DECODE: 1 cycle. HALT_REQ=1 -> HALT; else -> EXEC.
//   - EXEC:   1 cycle. NEED_MEM=1 -> MEM; else -> WB.
//   - MEM:    same handshake/timeout rules as FETCH. MEM_ACK=1 -> WB.
//   - WB:     1 cycle; INSTR_CNT+1, wrapping mod 2^CNT_W. RUN=1 -> FETCH; else -> IDLE.
//   - HALT:   HALTED=1, PH_*=0; terminal until RST. Halt instruction is not counted.
//   - ERR:    MEM_ERR=1, MEM_REQ=0; terminal until RST.
//   - Wait counter: cleared on every entry to FETCH/MEM; +1 per cycle with MEM_ACK=0 in FETCH/MEM.
//             Timeout hit = wait_cnt==MEM_TIMEOUT-1 with MEM_ACK=0, i.e. after MEM_TIMEOUT
//             no-ack cycles. MEM_ACK=1 in the same cycle wins over timeout.
//             Width $clog2(MEM_TIMEOUT+1), minimum 1. MEM_TIMEOUT=0: never times out.
//   - Latency with zero-wait ack: 4 cycles per non-mem instruction, 5 per mem instruction.
//             Each ack wait cycle adds 1.
//   - MEM_ACK outside FETCH/MEM, HALT_REQ outside DECODE, NEED_MEM outside EXEC: ignored.
//   - RUN deasserted mid-instruction: instruction completes through WB, then IDLE.
//             RUN only gates the IDLE->FETCH and WB->FETCH decisions.
//   - RST asserted mid-handshake: MEM_REQ drops next cycle. An ack arriving during or after
//             reset is ignored.
// STRUCTURE
//   - State encodings (`PSEQ_IDLE ... `PSEQ_ERR, 3 bits) and the MEM_TIMEOUT default go in the
//             shared definitions header, beside `SYS_CLK_HALF_PERIOD.
//   - One sub-module, mem_wait_timer: inputs clear, count_en; output timeout (parameter MEM_TIMEOUT).
//   - Next-state logic and registered state/counter are in the top module.
// TESTING
//   1. RST=1 for 2 cycles with RUN=1 -> all outputs 0, state IDLE. Release -> FETCH next cycle.
//   2. RUN=1, MEM_ACK tied 1, NEED_MEM=0, 3 instructions -> PH_* sequence F,D,E,W x3.
//             INSTR_CNT=3 after 12 cycles.
//   3. NEED_MEM=1, ack delayed 2 cycles in MEM -> PH_MEM high 3 cycles, then WB.
//             7 cycles for the instruction.
//   4. MEM_ACK=0 in FETCH, MEM_TIMEOUT=15 -> ERR after exactly 15 FETCH cycles.
//             MEM_ERR sticky, MEM_REQ=0. Repeat with ack on the 15th cycle -> DECODE, no ERR.
//   5. HALT_REQ=1 in DECODE -> HALTED=1, INSTR_CNT unchanged. Stays halted until RST.
//   6. RUN dropped during EXEC -> WB then IDLE. CNT_W=4 preloaded with 15 retirements -> wraps to 0.

Source files
------------

// File: rtl/proc_phase_sequencer_pkg.sv
// Shared definitions for the instruction phase sequencer: state encodings,
// clock and timeout defaults, and the wait-counter width helper.
package proc_phase_sequencer_pkg;

  localparam int SYS_CLK_HALF_PERIOD  = 5;
  localparam int PSEQ_MEM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    PSEQ_IDLE   = 3'd0,
    PSEQ_FETCH  = 3'd1,
    PSEQ_DECODE = 3'd2,
    PSEQ_EXEC   = 3'd3,
    PSEQ_MEM    = 3'd4,
    PSEQ_WB     = 3'd5,
    PSEQ_HALT   = 3'd6,
    PSEQ_ERR    = 3'd7
  } pseq_state_e;

  // Wide enough to hold MEM_TIMEOUT; never narrower than one bit.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/proc_phase_sequencer_mem_wait_timer.sv
// Counts consecutive no-ack cycles of a memory handshake and flags the cycle
// in which the tolerated number of waits runs out.
module mem_wait_timer
  import proc_phase_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = PSEQ_MEM_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_timeout
);

  localparam int               CW    = wait_cnt_w(MEM_TIMEOUT);
  localparam int               LIM   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0]    LIMIT = CW'(LIM);
  localparam logic             TO_ON = (MEM_TIMEOUT > 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the MEM_TIMEOUT-th no-ack cycle, so the FSM leaves on that edge.
  assign o_timeout = TO_ON && i_count_en && (r_cnt == LIMIT);

endmodule

// File: rtl/proc_phase_sequencer.sv
// Multicycle instruction phase sequencer: FETCH/DECODE/EXEC/[MEM]/WB with a
// req/ack memory handshake, retired-instruction counter, HALT and timeout ERR.
module proc_phase_sequencer
  import proc_phase_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = PSEQ_MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             HALT_REQ,
  input  logic             NEED_MEM,
  input  logic             MEM_ACK,
  output logic             MEM_REQ,
  output logic             PH_FETCH,
  output logic             PH_DECODE,
  output logic             PH_EXEC,
  output logic             PH_MEM,
  output logic             PH_WB,
  output logic             RETIRE,
  output logic             HALTED,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  pseq_state_e      r_state;
  pseq_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_in_mem;
  logic             w_wait_clr;
  logic             w_wait_en;
  logic             w_timeout;

  assign w_in_mem   = (r_state == PSEQ_FETCH) || (r_state == PSEQ_MEM);
  assign w_wait_en  = w_in_mem && !MEM_ACK;
  // Holding the counter clear outside FETCH/MEM guarantees it starts at 0 on entry.
  assign w_wait_clr = !w_in_mem || MEM_ACK;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clear    (w_wait_clr),
    .i_count_en (w_wait_en),
    .o_timeout  (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PSEQ_IDLE:   if (RUN) w_state_nxt = PSEQ_FETCH;
      PSEQ_FETCH: begin
        if (MEM_ACK)        w_state_nxt = PSEQ_DECODE;
        else if (w_timeout) w_state_nxt = PSEQ_ERR;
      end
      PSEQ_DECODE: w_state_nxt = HALT_REQ ? PSEQ_HALT : PSEQ_EXEC;
      PSEQ_EXEC:   w_state_nxt = NEED_MEM ? PSEQ_MEM : PSEQ_WB;
      PSEQ_MEM: begin
        if (MEM_ACK)        w_state_nxt = PSEQ_WB;
        else if (w_timeout) w_state_nxt = PSEQ_ERR;
      end
      PSEQ_WB:     w_state_nxt = RUN ? PSEQ_FETCH : PSEQ_IDLE;
      PSEQ_HALT:   w_state_nxt = PSEQ_HALT;
      PSEQ_ERR:    w_state_nxt = PSEQ_ERR;
      default:     w_state_nxt = PSEQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= PSEQ_IDLE;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == PSEQ_WB) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  assign MEM_REQ   = w_in_mem;
  assign PH_FETCH  = (r_state == PSEQ_FETCH);
  assign PH_DECODE = (r_state == PSEQ_DECODE);
  assign PH_EXEC   = (r_state == PSEQ_EXEC);
  assign PH_MEM    = (r_state == PSEQ_MEM);
  assign PH_WB     = (r_state == PSEQ_WB);
  assign RETIRE    = (r_state == PSEQ_WB);
  assign HALTED    = (r_state == PSEQ_HALT);
  assign MEM_ERR   = (r_state == PSEQ_ERR);
  assign INSTR_CNT = r_instr_cnt;

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Directed bench for proc_phase_sequencer: reset, plain and memory instructions,
// handshake timeout, halt and counter wrap with a 4-bit counter.
module tb_proc_phase_sequencer;
  import proc_phase_sequencer_pkg::*;

  localparam int CW = 4;

  localparam logic [4:0] P_F = 5'b10000;
  localparam logic [4:0] P_D = 5'b01000;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_M = 5'b00010;
  localparam logic [4:0] P_W = 5'b00001;
  localparam logic [4:0] P_0 = 5'b00000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RUN = 1'b0;
  logic          HALT_REQ = 1'b0;
  logic          NEED_MEM = 1'b0;
  logic          MEM_ACK = 1'b0;
  logic          MEM_REQ, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB;
  logic          RETIRE, HALTED, MEM_ERR;
  logic [CW-1:0] INSTR_CNT;
  logic [4:0]    ph;

  int vectors = 0;
  int miscompares = 0;

  proc_phase_sequencer #(
    .MEM_TIMEOUT (15),
    .CNT_W       (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RUN       (RUN),
    .HALT_REQ  (HALT_REQ),
    .NEED_MEM  (NEED_MEM),
    .MEM_ACK   (MEM_ACK),
    .MEM_REQ   (MEM_REQ),
    .PH_FETCH  (PH_FETCH),
    .PH_DECODE (PH_DECODE),
    .PH_EXEC   (PH_EXEC),
    .PH_MEM    (PH_MEM),
    .PH_WB     (PH_WB),
    .RETIRE    (RETIRE),
    .HALTED    (HALTED),
    .MEM_ERR   (MEM_ERR),
    .INSTR_CNT (INSTR_CNT)
  );

  assign ph = {PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB};

  always #(SYS_CLK_HALF_PERIOD) CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; RUN = 1'b1; MEM_ACK = 1'b1;
    tick();
    tick();
    vectors++;
    if (ph !== P_0) begin
      $display("FAIL reset_ph: got %b want %b", ph, P_0); miscompares++;
    end
    vectors++;
    if ({MEM_REQ, RETIRE, HALTED, MEM_ERR} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {MEM_REQ, RETIRE, HALTED, MEM_ERR});
      miscompares++;
    end
    vectors++;
    if (INSTR_CNT !== 4'd0) begin
      $display("FAIL reset_cnt: got %0d want 0", INSTR_CNT); miscompares++;
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (ph !== P_F || MEM_REQ !== 1'b1) begin
      $display("FAIL reset_release_fetch: got ph=%b req=%b want ph=%b req=1", ph, MEM_REQ, P_F);
      miscompares++;
    end
    // Reset mid-handshake drops the request on the next edge.
    MEM_ACK = 1'b0; RST = 1'b1;
    tick();
    vectors++;
    if (MEM_REQ !== 1'b0 || ph !== P_0) begin
      $display("FAIL reset_mid_req: got req=%b ph=%b want req=0 ph=%b", MEM_REQ, ph, P_0);
      miscompares++;
    end
    MEM_ACK = 1'b1; RUN = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    tick();
    vectors++;
    if (ph !== P_0 || MEM_REQ !== 1'b0) begin
      $display("FAIL reset_stray_ack: got ph=%b req=%b want ph=%b req=0", ph, MEM_REQ, P_0);
      miscompares++;
    end
  endtask

  task automatic test_basic;
    logic [4:0] seq [4] = '{P_F, P_D, P_E, P_W};
    do_reset();
    RUN = 1'b1; MEM_ACK = 1'b1; NEED_MEM = 1'b0; HALT_REQ = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (ph !== seq[i % 4]) begin
        $display("FAIL basic_ph[%0d]: got %b want %b", i, ph, seq[i % 4]); miscompares++;
      end
      if (i % 4 == 3) begin
        vectors++;
        if (RETIRE !== 1'b1) begin
          $display("FAIL basic_retire[%0d]: got %b want 1", i, RETIRE); miscompares++;
        end
      end
      if (i % 4 == 0 && i > 0) begin
        vectors++;
        if (INSTR_CNT !== CW'(i / 4)) begin
          $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, INSTR_CNT, i / 4); miscompares++;
        end
      end
    end
    RUN = 1'b0;
    tick();
    vectors++;
    if (INSTR_CNT !== 4'd3 || ph !== P_0) begin
      $display("FAIL basic_end: got cnt=%0d ph=%b want cnt=3 ph=%b", INSTR_CNT, ph, P_0);
      miscompares++;
    end
  endtask

  task automatic test_mem_wait;
    logic [4:0] exp [8] = '{P_F, P_D, P_E, P_M, P_M, P_M, P_W, P_0};
    logic       ack [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    RUN = 1'b1; MEM_ACK = 1'b1; NEED_MEM = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      RUN = 1'b0;
      vectors++;
      if (ph !== exp[k] || MEM_REQ !== (exp[k] == P_F || exp[k] == P_M)) begin
        $display("FAIL mem_ph[%0d]: got ph=%b req=%b want ph=%b", k, ph, MEM_REQ, exp[k]);
        miscompares++;
      end
      MEM_ACK = ack[k];
    end
    vectors++;
    if (INSTR_CNT !== 4'd1) begin
      $display("FAIL mem_cnt: got %0d want 1", INSTR_CNT); miscompares++;
    end
    NEED_MEM = 1'b0;
  endtask

  task automatic test_timeout;
    do_reset();
    RUN = 1'b1; MEM_ACK = 1'b0;
    tick();
    for (int k = 1; k <= 15; k++) begin
      vectors++;
      if (ph !== P_F || MEM_ERR !== 1'b0) begin
        $display("FAIL to_fetch[%0d]: got ph=%b err=%b want ph=%b err=0", k, ph, MEM_ERR, P_F);
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (MEM_ERR !== 1'b1 || MEM_REQ !== 1'b0 || ph !== P_0) begin
      $display("FAIL to_err: got err=%b req=%b ph=%b want err=1 req=0 ph=%b", MEM_ERR, MEM_REQ, ph, P_0);
      miscompares++;
    end
    MEM_ACK = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (MEM_ERR !== 1'b1 || MEM_REQ !== 1'b0) begin
      $display("FAIL to_sticky: got err=%b req=%b want err=1 req=0", MEM_ERR, MEM_REQ);
      miscompares++;
    end
    // Ack on the last tolerated cycle beats the timeout.
    do_reset();
    MEM_ACK = 1'b0;
    tick();
    for (int k = 1; k < 15; k++) tick();
    vectors++;
    if (ph !== P_F) begin
      $display("FAIL to_15th_fetch: got %b want %b", ph, P_F); miscompares++;
    end
    MEM_ACK = 1'b1;
    tick();
    vectors++;
    if (ph !== P_D || MEM_ERR !== 1'b0) begin
      $display("FAIL to_ack_wins: got ph=%b err=%b want ph=%b err=0", ph, MEM_ERR, P_D);
      miscompares++;
    end
  endtask

  task automatic test_halt;
    do_reset();
    RUN = 1'b1; MEM_ACK = 1'b1; NEED_MEM = 1'b0;
    tick();                       // FETCH: halt request here is ignored
    HALT_REQ = 1'b1;
    tick();                       // DECODE
    HALT_REQ = 1'b0;
    tick();                       // EXEC
    HALT_REQ = 1'b1;
    vectors++;
    if (ph !== P_E || HALTED !== 1'b0) begin
      $display("FAIL halt_ignored: got ph=%b halted=%b want ph=%b halted=0", ph, HALTED, P_E);
      miscompares++;
    end
    tick();                       // WB
    tick();                       // FETCH
    tick();                       // DECODE with HALT_REQ=1
    tick();
    vectors++;
    if (HALTED !== 1'b1 || ph !== P_0 || MEM_REQ !== 1'b0) begin
      $display("FAIL halt_enter: got halted=%b ph=%b req=%b want halted=1 ph=%b req=0", HALTED, ph, MEM_REQ, P_0);
      miscompares++;
    end
    vectors++;
    if (INSTR_CNT !== 4'd1) begin
      $display("FAIL halt_cnt: got %0d want 1", INSTR_CNT); miscompares++;
    end
    HALT_REQ = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (HALTED !== 1'b1 || INSTR_CNT !== 4'd1) begin
      $display("FAIL halt_sticky: got halted=%b cnt=%0d want halted=1 cnt=1", HALTED, INSTR_CNT);
      miscompares++;
    end
    do_reset();
    vectors++;
    if (HALTED !== 1'b0 || INSTR_CNT !== 4'd0) begin
      $display("FAIL halt_clear: got halted=%b cnt=%0d want halted=0 cnt=0", HALTED, INSTR_CNT);
      miscompares++;
    end
  endtask

  task automatic test_wrap;
    do_reset();
    RUN = 1'b1; MEM_ACK = 1'b1; NEED_MEM = 1'b0; HALT_REQ = 1'b0;
    for (int k = 0; k < 61; k++) tick();
    vectors++;
    if (INSTR_CNT !== 4'd15 || ph !== P_F) begin
      $display("FAIL wrap_pre: got cnt=%0d ph=%b want cnt=15 ph=%b", INSTR_CNT, ph, P_F);
      miscompares++;
    end
    tick();
    tick();
    RUN = 1'b0;                   // dropped during EXEC
    tick();
    vectors++;
    if (ph !== P_W || RETIRE !== 1'b1) begin
      $display("FAIL wrap_wb: got ph=%b retire=%b want ph=%b retire=1", ph, RETIRE, P_W);
      miscompares++;
    end
    tick();
    vectors++;
    if (INSTR_CNT !== 4'd0 || ph !== P_0) begin
      $display("FAIL wrap_cnt: got cnt=%0d ph=%b want cnt=0 ph=%b", INSTR_CNT, ph, P_0);
      miscompares++;
    end
    tick();
    vectors++;
    if (ph !== P_0 || MEM_REQ !== 1'b0) begin
      $display("FAIL wrap_idle: got ph=%b req=%b want ph=%b req=0", ph, MEM_REQ, P_0);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
